// File: rtl/fsm_sequencer_if.sv
// Instruction-memory link of the sequencer: the state address goes out and the
// decoded word fields of that state come back in the same cycle.
interface fsm_sequencer_if #(
  parameter int STATE_COUNT   = 8,
  parameter int COND_WIDTH    = 3,
  parameter int OUTPUT_WIDTH  = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int COUNTER_COUNT = 2
);
  localparam int SW = $clog2(STATE_COUNT);

  logic [SW-1:0]                          addr;
  logic [SW-1:0]                          jump_target;
  logic                                   repeat_state;
  logic                                   slow_mode;
  logic [OUTPUT_WIDTH-1:0]                output_opcode;
  logic [COND_WIDTH-1:0]                  cond;
  logic                                   then_action;
  logic                                   else_action;
  logic [COUNTER_WIDTH*COUNTER_COUNT-1:0] const_data;

  modport master (
    output addr,
    input  jump_target, repeat_state, slow_mode, output_opcode,
    input  cond, then_action, else_action, const_data
  );

  modport slave (
    input  addr,
    output jump_target, repeat_state, slow_mode, output_opcode,
    output cond, then_action, else_action, const_data
  );
endinterface

// File: rtl/fsm_sequencer.sv
// Execution core of the microcoded FSM: run-control mode machine, state register,
// per-constant down-counters, slow-mode prescaler and input synchroniser.
module fsm_sequencer #(
  parameter int STATE_COUNT    = 8,
  parameter int COND_WIDTH     = 3,
  parameter int OUTPUT_WIDTH   = 4,
  parameter int COUNTER_WIDTH  = 16,
  parameter int COUNTER_COUNT  = 2,
  parameter int INPUT_WIDTH    = 5,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [INPUT_WIDTH-1:0]   fsm_in,
  fsm_sequencer_if.master          mem,
  output logic [OUTPUT_WIDTH-1:0]  fsm_out,
  output logic                     running,
  output logic [COUNTER_COUNT-1:0] expired
);
  localparam int SW       = $clog2(STATE_COUNT);
  localparam int CV_WIDTH = 2**COND_WIDTH;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_RUN  = 2'd2
  } mode_t;

  mode_t                     mode_r, mode_s;
  logic [SW-1:0]             state_r, state_s;
  logic [PRESCALE_WIDTH-1:0] presc_r, presc_s;
  logic [OUTPUT_WIDTH-1:0]   out_r, out_s;
  logic [COUNTER_WIDTH-1:0]  cnt_r    [COUNTER_COUNT];
  logic [COUNTER_WIDTH-1:0]  cnt_s    [COUNTER_COUNT];
  logic [COUNTER_WIDTH-1:0]  reload_s [COUNTER_COUNT];
  logic [INPUT_WIDTH-1:0]    sync1_r, sync2_r;
  logic [CV_WIDTH-1:0]       cv_s;
  logic [SW-1:0]             target_s;
  logic                      tick_s;
  logic                      action_s;

  genvar k;
  generate
    for (k = 0; k < COUNTER_COUNT; k = k + 1) begin : g_cnt
      assign reload_s[k] = mem.const_data[k*COUNTER_WIDTH +: COUNTER_WIDTH];
      assign expired[k]  = (cnt_r[k] == {COUNTER_WIDTH{1'b0}});
    end
  endgenerate

  // Out-of-range jump targets only exist when STATE_COUNT is not a power of two.
  generate
    if (STATE_COUNT == (1 << SW)) begin : g_tgt_full
      assign target_s = mem.jump_target;
    end else begin : g_tgt_clip
      assign target_s = (int'(mem.jump_target) >= STATE_COUNT) ? {SW{1'b0}} : mem.jump_target;
    end
  endgenerate

  assign cv_s     = {sync2_r, expired, 1'b1};
  assign tick_s   = !mem.slow_mode || (presc_r == {PRESCALE_WIDTH{1'b1}});
  assign action_s = cv_s[mem.cond] ? mem.then_action : mem.else_action;

  assign mem.addr = state_r;
  assign fsm_out  = out_r;
  assign running  = (mode_r == MODE_RUN);

  // Next-state logic for mode, state, counters, prescaler and output opcode.
  always_comb begin
    mode_s  = mode_r;
    state_s = state_r;
    presc_s = presc_r;
    out_s   = out_r;
    cnt_s   = cnt_r;
    case (mode_r)
      MODE_IDLE: begin
        state_s = {SW{1'b0}};
        out_s   = {OUTPUT_WIDTH{1'b0}};
        presc_s = {PRESCALE_WIDTH{1'b0}};
        if (run) begin
          mode_s = MODE_LOAD;
        end else begin
          mode_s = MODE_IDLE;
        end
      end
      MODE_LOAD: begin
        cnt_s   = reload_s;
        presc_s = {PRESCALE_WIDTH{1'b0}};
        out_s   = mem.output_opcode;
        if (run) begin
          mode_s = MODE_RUN;
        end else begin
          mode_s = MODE_IDLE;
        end
      end
      MODE_RUN: begin
        if (!run) begin
          mode_s  = MODE_IDLE;
          state_s = {SW{1'b0}};
          out_s   = {OUTPUT_WIDTH{1'b0}};
        end else begin
          out_s   = mem.output_opcode;
          presc_s = presc_r + PRESCALE_WIDTH'(1);
          if (tick_s && action_s) begin
            state_s = mem.repeat_state ? state_r : target_s;
            cnt_s   = reload_s;
            presc_s = {PRESCALE_WIDTH{1'b0}};
          end else if (tick_s) begin
            // HOLD saturates at zero so an expired timer stays expired.
            for (int i = 0; i < COUNTER_COUNT; i++) begin
              if (cnt_r[i] != {COUNTER_WIDTH{1'b0}}) begin
                cnt_s[i] = cnt_r[i] - COUNTER_WIDTH'(1);
              end else begin
                cnt_s[i] = cnt_r[i];
              end
            end
          end else begin
            state_s = state_r;
          end
        end
      end
      default: begin
        mode_s  = MODE_IDLE;
        state_s = {SW{1'b0}};
        out_s   = {OUTPUT_WIDTH{1'b0}};
        presc_s = {PRESCALE_WIDTH{1'b0}};
      end
    endcase
  end

  // State registers and input synchroniser with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mode_r  <= MODE_IDLE;
      state_r <= {SW{1'b0}};
      presc_r <= {PRESCALE_WIDTH{1'b0}};
      out_r   <= {OUTPUT_WIDTH{1'b0}};
      sync1_r <= {INPUT_WIDTH{1'b0}};
      sync2_r <= {INPUT_WIDTH{1'b0}};
      for (int i = 0; i < COUNTER_COUNT; i++) begin
        cnt_r[i] <= {COUNTER_WIDTH{1'b0}};
      end
    end else begin
      mode_r  <= mode_s;
      state_r <= state_s;
      presc_r <= presc_s;
      out_r   <= out_s;
      sync1_r <= fsm_in;
      sync2_r <= sync1_r;
      cnt_r   <= cnt_s;
    end
  end
endmodule

// File: tb/tb_fsm_sequencer.sv
// Randomised and directed bench for fsm_sequencer with a cycle-level reference
// model derived from the sequencer's behavioural rules.
module tb_fsm_sequencer;
  localparam int SC = 8;
  localparam int OW = 4;
  localparam int NC = 2;
  localparam int IW = 5;

  typedef struct packed {
    logic [2:0]  jt;
    logic        rep;
    logic        slow;
    logic [3:0]  op;
    logic [2:0]  cond;
    logic        th;
    logic        el;
    logic [15:0] c0;
    logic [15:0] c1;
  } word_t;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          run;
  logic [IW-1:0] fsm_in;
  logic [OW-1:0] fsm_out;
  logic          running;
  logic [NC-1:0] expired;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  word_t words [SC];

  int         m_mode = 0;
  logic [2:0] m_state = 3'd0;
  int         m_cnt [NC];
  int         m_presc = 0;
  logic [4:0] m_h1 = 5'd0;
  logic [4:0] m_h2 = 5'd0;
  logic [3:0] m_out = 4'd0;

  fsm_sequencer_if bus ();

  fsm_sequencer dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .run     (run),
    .fsm_in  (fsm_in),
    .mem     (bus),
    .fsm_out (fsm_out),
    .running (running),
    .expired (expired)
  );

  always #5 clock = ~clock;

  always_comb begin
    bus.jump_target   = words[bus.addr].jt;
    bus.repeat_state  = words[bus.addr].rep;
    bus.slow_mode     = words[bus.addr].slow;
    bus.output_opcode = words[bus.addr].op;
    bus.cond          = words[bus.addr].cond;
    bus.then_action   = words[bus.addr].th;
    bus.else_action   = words[bus.addr].el;
    bus.const_data    = {words[bus.addr].c1, words[bus.addr].c0};
  end

  function automatic word_t mkw(input int jt, input int rep, input int slow, input int op,
                                input int cond, input int th, input int el,
                                input int c0, input int c1);
    word_t w;
    w.jt = 3'(jt); w.rep = 1'(rep); w.slow = 1'(slow); w.op = 4'(op);
    w.cond = 3'(cond); w.th = 1'(th); w.el = 1'(el); w.c0 = 16'(c0); w.c1 = 16'(c1);
    return w;
  endfunction

  function automatic word_t rand_word();
    return mkw($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 1 : 0,
               ($urandom_range(0, 15) == 0) ? 1 : 0, $urandom_range(0, 15),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 6), $urandom_range(0, 6));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 load, 2 run; inputs seen two edges late.
  always @(posedge clock) begin
    word_t w;
    logic [4:0] seen;
    bit tick, c, act;
    if (!rst_n) begin
      m_mode = 0; m_state = 3'd0; m_presc = 0; m_h1 = 5'd0; m_h2 = 5'd0; m_out = 4'd0;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    end else begin
      w = words[m_state];
      seen = m_h2;
      m_h2 = m_h1;
      m_h1 = fsm_in;
      if (m_mode == 0) begin
        m_state = 3'd0; m_out = 4'd0; m_presc = 0;
        if (run) m_mode = 1;
      end else if (m_mode == 1) begin
        m_cnt[0] = int'(w.c0); m_cnt[1] = int'(w.c1);
        m_presc = 0; m_out = w.op;
        m_mode = run ? 2 : 0;
      end else if (!run) begin
        m_mode = 0; m_state = 3'd0; m_out = 4'd0;
      end else begin
        m_out = w.op;
        tick = !w.slow || (m_presc == 255);
        m_presc = (m_presc + 1) % 256;
        if (tick) begin
          if (w.cond == 3'd0) c = 1'b1;
          else if (int'(w.cond) <= NC) c = (m_cnt[int'(w.cond) - 1] == 0);
          else c = seen[int'(w.cond) - 1 - NC];
          act = c ? w.th : w.el;
          if (act) begin
            if (!w.rep) m_state = (int'(w.jt) >= SC) ? 3'd0 : w.jt;
            m_cnt[0] = int'(w.c0); m_cnt[1] = int'(w.c1);
            m_presc = 0;
          end else begin
            for (int i = 0; i < NC; i++) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("addr", 32'(bus.addr), 32'(m_state));
      chk("fsm_out", 32'(fsm_out), 32'(m_out));
      chk("running", 32'(running), 32'(m_mode == 2));
      chk("expired", 32'(expired), 32'({m_cnt[1] == 0, m_cnt[0] == 0}));
    end
  end

  initial begin
    rst_n = 1'b0; run = 1'b1; fsm_in = 5'd0;
    words[0] = mkw(3, 0, 0, 4'hA, 1, 1, 0, 5, 7);
    words[1] = mkw(4, 0, 0, 4'h1, 0, 1, 0, 2, 2);
    words[2] = mkw(1, 0, 1, 4'h6, 0, 1, 0, 2, 2);
    words[3] = mkw(2, 0, 0, 4'h5, 3, 1, 0, 9, 9);
    words[4] = mkw(4, 1, 0, 4'h7, 0, 1, 0, 3, 3);
    words[5] = mkw(6, 0, 0, 4'h8, 1, 1, 0, 4, 4);
    words[6] = mkw(0, 0, 0, 4'h9, 0, 1, 0, 1, 1);
    words[7] = mkw(0, 0, 0, 4'hB, 0, 1, 0, 1, 1);
    @(negedge clock);
    cmp_en = 1'b1;
    @(negedge clock);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_fsm_out", 32'(fsm_out), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    rst_n = 1'b1;
    @(negedge clock);
    chk("load_running", 32'(running), 32'd0);
    @(negedge clock);
    chk("run_running", 32'(running), 32'd1);
    chk("run_fsm_out", 32'(fsm_out), 32'hA);
    chk("run_expired", 32'(expired), 32'd0);
    repeat (5) @(negedge clock);
    chk("timeout_hold_addr", 32'(bus.addr), 32'd0);
    chk("timeout_expired", 32'(expired), 32'd1);
    @(negedge clock);
    chk("timeout_go_addr", 32'(bus.addr), 32'd3);
    chk("timeout_reload", 32'(expired), 32'd0);
    fsm_in = 5'd1;
    @(negedge clock);
    chk("sync_e1_addr", 32'(bus.addr), 32'd3);
    chk("sync_e1_fsm_out", 32'(fsm_out), 32'h5);
    @(negedge clock);
    chk("sync_e2_addr", 32'(bus.addr), 32'd3);
    @(negedge clock);
    chk("sync_e3_addr", 32'(bus.addr), 32'd2);
    fsm_in = 5'd0;
    repeat (255) @(negedge clock);
    chk("slow_255_addr", 32'(bus.addr), 32'd2);
    @(negedge clock);
    chk("slow_256_addr", 32'(bus.addr), 32'd1);
    @(negedge clock);
    chk("fast_addr", 32'(bus.addr), 32'd4);
    repeat (10) @(negedge clock);
    chk("repeat_addr", 32'(bus.addr), 32'd4);
    chk("repeat_expired", 32'(expired), 32'd0);
    words[4].rep = 1'b0;
    words[4].jt = 3'd5;
    @(negedge clock);
    chk("to5_addr", 32'(bus.addr), 32'd5);
    @(negedge clock);
    chk("hold5_addr", 32'(bus.addr), 32'd5);
    run = 1'b0;
    @(negedge clock);
    chk("stop_addr", 32'(bus.addr), 32'd0);
    chk("stop_fsm_out", 32'(fsm_out), 32'd0);
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_expired", 32'(expired), 32'd0);
    run = 1'b1;
    @(negedge clock);
    chk("reload_running", 32'(running), 32'd0);
    @(negedge clock);
    chk("rerun_running", 32'(running), 32'd1);
    chk("rerun_fsm_out", 32'(fsm_out), 32'hA);
    repeat (5) @(negedge clock);
    chk("rerun_expired", 32'(expired), 32'd1);
    chk("rerun_addr", 32'(bus.addr), 32'd0);
    rst_n = 1'b0;
    @(negedge clock);
    chk("midrst_addr", 32'(bus.addr), 32'd0);
    chk("midrst_fsm_out", 32'(fsm_out), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_expired", 32'(expired), 32'd3);
    rst_n = 1'b1;

    for (int i = 0; i < SC; i++) words[i] = rand_word();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      fsm_in = 5'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) run = ~run;
      if ($urandom_range(0, 19) == 0) words[$urandom_range(0, 7)] = rand_word();
    end
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
